// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: subtracts A-B one CHUNK-bit slice per cycle (LSB first)
// through a single slice subtractor with a registered borrow, then reports eq/lt/gt.
module seq_comparator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              sm_q, sm_d;
  logic              borrow_q, borrow_d;
  logic              nz_q, nz_d;
  logic              eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;

  logic [CHUNK:0]    diff;
  logic              slice_nz, amsb, bmsb, dmsb, ovf, last, accept;

  always_comb begin
    // Operands shift right each RUN cycle, so the current slice A[idx] always sits at the bottom.
    diff     = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow_q};
    slice_nz = |diff[CHUNK-1:0];
    amsb     = a_q[CHUNK-1];
    bmsb     = b_q[CHUNK-1];
    dmsb     = diff[CHUNK-1];
    ovf      = (amsb ^ bmsb) & (amsb ^ dmsb);
    last     = (idx_q == IdxW'(N - 1));
    accept   = start && (state_q == StIdle || state_q == StDone);

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    sm_d     = sm_q;
    borrow_d = borrow_q;
    nz_d     = nz_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    gt_d     = gt_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        borrow_d = diff[CHUNK];
        nz_d     = nz_q | slice_nz;
        idx_d    = idx_q + IdxW'(1);
        if (last) begin
          eq_d    = !(nz_q | slice_nz);
          lt_d    = sm_q ? (dmsb ^ ovf) : diff[CHUNK];
          gt_d    = !eq_d && !lt_d;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      a_d      = a;
      b_d      = b;
      sm_d     = signed_mode;
      borrow_d = 1'b0;
      nz_d     = 1'b0;
      idx_d    = '0;
      state_d  = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      sm_q     <= 1'b0;
      borrow_q <= 1'b0;
      nz_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      sm_q     <= sm_d;
      borrow_q <= borrow_d;
      nz_q     <= nz_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: five parameterisations share one stimulus; a timeline model predicts
// busy/done/flags every cycle, and directed cases pin the 32/8 instance with literal results.
module tb_seq_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sm = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic busy_v [5];
  logic done_v [5];
  logic eq_v   [5];
  logic lt_v   [5];
  logic gt_v   [5];

  // Config order: 32/8, 32/1, 32/4, 32/32, 16/16
  int nsl [5] = '{4, 32, 8, 1, 1};
  int wid [5] = '{32, 32, 32, 32, 16};

  always #5 clk = ~clk;

  seq_comparator #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .eq(eq_v[0]), .lt(lt_v[0]), .gt(gt_v[0]));
  seq_comparator #(.WIDTH(32), .CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .eq(eq_v[1]), .lt(lt_v[1]), .gt(gt_v[1]));
  seq_comparator #(.WIDTH(32), .CHUNK(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .eq(eq_v[2]), .lt(lt_v[2]), .gt(gt_v[2]));
  seq_comparator #(.WIDTH(32), .CHUNK(32)) u3 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy_v[3]), .done(done_v[3]), .eq(eq_v[3]), .lt(lt_v[3]), .gt(gt_v[3]));
  seq_comparator #(.WIDTH(16), .CHUNK(16)) u4 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a[15:0]), .b(b[15:0]),
    .busy(busy_v[4]), .done(done_v[4]), .eq(eq_v[4]), .lt(lt_v[4]), .gt(gt_v[4]));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference compare: {eq, lt, gt} from plain integer arithmetic.
  function automatic logic [2:0] ref_cmp(logic [31:0] x, logic [31:0] y, logic s, int w);
    longint xv, yv;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    x = x & mask;
    y = y & mask;
    xv = longint'({32'b0, x});
    yv = longint'({32'b0, y});
    if (s && x[w-1]) xv = xv - (64'sd1 <<< w);
    if (s && y[w-1]) yv = yv - (64'sd1 <<< w);
    return {xv == yv, xv < yv, xv > yv};
  endfunction

  // Timeline model: an accepted start gives N busy cycles, then a one-cycle done with new flags.
  int       run_left [5] = '{0, 0, 0, 0, 0};
  bit       done_m   [5];
  bit [2:0] flags_m  [5];
  bit [2:0] pend     [5];

  always @(posedge clk) begin
    for (int c = 0; c < 5; c++) begin
      if (rst) begin
        run_left[c] = 0;
        done_m[c]   = 1'b0;
        flags_m[c]  = 3'b000;
      end else if (run_left[c] > 0) begin
        run_left[c] = run_left[c] - 1;
        done_m[c]   = (run_left[c] == 0);
        if (done_m[c]) flags_m[c] = pend[c];
      end else begin
        done_m[c] = 1'b0;
        if (start) begin
          pend[c]     = ref_cmp(a, b, sm, wid[c]);
          run_left[c] = nsl[c];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 5; c++) begin
        check($sformatf("busy[%0d]", c), 32'(busy_v[c]), 32'(run_left[c] > 0));
        check($sformatf("done[%0d]", c), 32'(done_v[c]), 32'(done_m[c]));
        check($sformatf("flags[%0d]", c), 32'({eq_v[c], lt_v[c], gt_v[c]}), 32'(flags_m[c]));
      end
    end
  end

  task automatic run_cmp(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output int lat);
    @(negedge clk);
    a = x; b = y; sm = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done_v[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done0(output int lat);
    lat = 0;
    while (!done_v[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  int pulses;
  logic [2:0] seen;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs", 32'({busy_v[0], done_v[0], eq_v[0], lt_v[0], gt_v[0]}), 32'd0);
    rst = 1'b0;

    run_cmp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, lat);
    check("eq_latency", lat, 5);
    check("eq_flags", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b100);

    run_cmp(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat);
    check("unsigned_1_vs_ff", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b010);
    run_cmp(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, lat);
    check("signed_1_vs_m1", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b001);
    run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, lat);
    check("signed_ovf", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b010);
    run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, lat);
    check("unsigned_ovf", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b001);
    check("ovf_latency", lat, 5);

    // start pulsed mid-run and operands changed afterwards must not disturb the compare
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1234_5678; sm = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 32'h0000_0001; b = 32'h0000_0002; start = 1'b1;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0; start = 1'b0;
    pulses = 0;
    seen = 3'b000;
    repeat (8) begin
      @(negedge clk);
      if (done_v[0]) begin
        pulses++;
        seen = {eq_v[0], lt_v[0], gt_v[0]};
      end
    end
    check("midrun_pulses", pulses, 1);
    check("midrun_flags", 32'(seen), 32'b100);
    repeat (30) @(negedge clk);

    // start held through DONE: next compare begins with no idle cycle
    @(negedge clk);
    a = 32'd5; b = 32'd3; sm = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done0(lat);
    check("b2b_first_flags", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b001);
    a = 32'd3; b = 32'd5;
    @(negedge clk);
    check("b2b_no_idle", 32'(busy_v[0]), 32'd1);
    start = 1'b0;
    wait_done0(lat);
    check("b2b_second_latency", lat, 4);
    check("b2b_second_flags", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b010);
    repeat (40) @(negedge clk);

    // reset in the second RUN cycle aborts the compare
    @(negedge clk);
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", 32'({busy_v[0], done_v[0], eq_v[0], lt_v[0], gt_v[0]}), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_v[0]) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run_cmp(32'd5, 32'd3, 1'b0, lat);
    check("after_abort_gt", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b001);
    check("after_abort_latency", lat, 5);
    repeat (40) @(negedge clk);

    // random sweep, all configs checked cycle-by-cycle against the model
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a = $urandom;
      b = (i % 8 == 3) ? a : $urandom;
      if (i % 16 == 5) b = {a[31:16], b[15:0]};
      sm = i[0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (33) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_comparator.md
# seq_comparator

Parametrised multi-cycle magnitude comparator for the datapath compare unit. It compares two WIDTH-bit operands one CHUNK-bit slice per cycle, LSB slice first, using a single slice subtractor with a registered borrow. After WIDTH/CHUNK cycles it reports equal / less-than / greater-than in unsigned or two's-complement signed mode. A start/done handshake lets the control unit issue comparisons at a reduced adder cost.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, slice width processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a comparison; sampled only in IDLE or DONE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while slices are being processed (RUN).
- done  output  1  one-cycle pulse, high in DONE; results valid from this cycle.
- eq  output  1  A == B.
- lt  output  1  A < B under the latched mode.
- gt  output  1  A > B under the latched mode.

## Operation
- N = WIDTH/CHUNK slices; slice index counter is ceil(log2(N+1)) bits wide.
- States are IDLE, RUN, and DONE.
- IDLE:
  - On start=1, latch a, b and signed_mode.
  - Clear the borrow register and the nonzero accumulator.
  - Set idx=0 and go to RUN.
- RUN:
  - Compute the slice difference d = A[idx] − B[idx] − borrow, CHUNK+1 bits.
  - Register the new borrow from bit CHUNK of d.
  - OR-accumulate (d[CHUNK-1:0] != 0) into the nonzero accumulator.
  - Increment idx.
  - When idx == N−1, also compute the final flags and go to DONE.
- Final flags:
  - eq = !(nonzero | slice nonzero).
  - Unsigned lt = final borrow out.
  - Signed lt = dmsb ^ ovf. Here dmsb is the MSB of the top slice difference, amsb/bmsb are the operand MSBs, and ovf = (amsb ^ bmsb) & (amsb ^ dmsb).
  - gt = !eq & !lt.
  - Exactly one of eq/lt/gt is 1 after any completed compare.
- DONE:
  - done=1 for exactly one cycle.
  - On start=1, latch new operands and go to RUN (back-to-back); otherwise go to IDLE.
- Results eq/lt/gt are held from DONE until the DONE of the next compare. They are not cleared on the next start.
- start in RUN is ignored; the latched operands are not disturbed.
- Input changes on a, b or signed_mode after the start edge have no effect.
- N=1 (CHUNK=WIDTH) is legal: RUN lasts one cycle.

## Timing
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, eq=0, lt=0, gt=0.
  - Borrow, accumulator and idx are cleared.
- Reset during RUN or DONE aborts the compare. No done pulse follows.
- Start accepted at edge k:
  - busy=1 for cycles k..k+N−1 (after edges k..k+N−1).
  - done=1 and results valid in cycle k+N.
- Latency is N+1 edges from the start edge to results visible: 5 for WIDTH=32, CHUNK=8.
- Back-to-back throughput: one compare every N+1 cycles.
- done and busy are never high simultaneously.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Equal, unsigned, WIDTH=32, CHUNK=8:
  - Stimulus: a=b=0xDEADBEEF, signed_mode=0, start at edge k.
  - Response: busy high for 4 cycles, done in cycle k+4 with eq=1, lt=0, gt=0.
- Mode dependence:
  - a=0x00000001, b=0xFFFFFFFF, unsigned -> lt=1.
  - Same operands, signed -> gt=1 (1 > −1).
- Signed overflow path:
  - a=0x80000000, b=0x7FFFFFFF, signed -> lt=1.
  - Same operands, unsigned -> gt=1.
- Handshake robustness:
  - Pulse start with new operands during RUN, and change a/b mid-run. Results must match the originally latched operands; exactly one done pulse.
  - A start held high in DONE begins the next compare with no idle cycle.
- Reset mid-operation:
  - Assert rst in the second RUN cycle. All outputs become 0 next cycle and no done is produced.
  - A fresh compare of a=5, b=3 then gives gt=1.
- Parameter sweep:
  - CHUNK ∈ {1, 4, 8, 32} at WIDTH=32, plus WIDTH=16/CHUNK=16, with 1000 random signed and unsigned pairs each.
  - Flags must match a reference compare; done latency must equal WIDTH/CHUNK+1.
